// File: rtl/wb_grf.sv
// -----------------------------------------------------------------------------
// wb_grf -- writeback stage and general register file of the 5-stage MIPS core
//
// Decodes the instruction sitting in WB, works out which register it writes
// (if any) and with what value, and commits that write into a 32x32 register
// file on the rising clock edge. Two combinational read ports serve the decode
// stage; each one forwards the pending WB write in the same cycle so decode
// never sees a stale value for the register being written back.
//
// Ports
//   clk      in   1   pipeline clock, writes on rising edge
//   reset    in   1   asynchronous active-low reset, clears $1..$31
//   ir_w     in  32   instruction in WB
//   pc4_w    in  32   PC+4 of the WB instruction
//   pc8_w    in  32   PC+8 of the WB instruction (jal link value)
//   alu_w    in  32   ALU result carried to WB
//   rd_w     in  32   data-memory read data carried to WB
//   rs_addr  in   5   read port A address
//   rt_addr  in   5   read port B address
//   rs_data  out 32   read port A data
//   rt_data  out 32   read port B data
//   wb_we    out  1   a write is committed at the next rising edge
//   wb_addr  out  5   destination of the pending write
//   wb_data  out 32   data of the pending write
//   wb_pc    out 32   PC of the WB instruction (pc4_w - 4)
// -----------------------------------------------------------------------------
module wb_grf #(
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir_w,
    input  logic [31:0] pc4_w,
    input  logic [31:0] pc8_w,
    input  logic [31:0] alu_w,
    input  logic [31:0] rd_w,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc
);

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] FN_ADDU   = 6'h21;
    localparam logic [5:0] FN_SUBU   = 6'h23;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt_fld;
    logic [4:0]  rd_fld;
    logic        writes;
    logic [31:0] regs [0:31];

    assign op     = ir_w[31:26];
    assign funct  = ir_w[5:0];
    assign rt_fld = ir_w[20:16];
    assign rd_fld = ir_w[15:11];

    // rs and shamt fields play no part in writeback selection
    logic unused_fields;
    assign unused_fields = ^{ir_w[25:21], ir_w[10:6]};

    // Destination/data decode. wb_addr and wb_data keep the decoded values even
    // for a $0 destination; only the enable is suppressed there.
    always_comb begin
        writes  = 1'b0;
        wb_addr = 5'd0;
        wb_data = 32'd0;
        case (op)
            OP_RTYPE: begin
                if (funct == FN_ADDU || funct == FN_SUBU) begin
                    writes  = 1'b1;
                    wb_addr = rd_fld;
                    wb_data = alu_w;
                end
            end
            OP_ORI, OP_LUI: begin
                writes  = 1'b1;
                wb_addr = rt_fld;
                wb_data = alu_w;
            end
            OP_LW: begin
                writes  = 1'b1;
                wb_addr = rt_fld;
                wb_data = rd_w;
            end
            OP_JAL: begin
                writes  = 1'b1;
                wb_addr = 5'd31;
                wb_data = pc8_w;
            end
            default: begin
                writes  = 1'b0;
                wb_addr = 5'd0;
                wb_data = 32'd0;
            end
        endcase
    end

    assign wb_we = writes && (wb_addr != 5'd0);
    assign wb_pc = pc4_w - 32'd4;

    // $0 is held at zero; wb_we already excludes it as a destination.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs[0] <= 32'd0;
            for (int i = 1; i < 32; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (wb_we) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rs_data = regs[rs_addr];
        if (rs_addr == 5'd0) begin
            rs_data = 32'd0;
        end else if (wb_we && rs_addr == wb_addr) begin
            rs_data = wb_data;
        end
    end

    always_comb begin
        rt_data = regs[rt_addr];
        if (rt_addr == 5'd0) begin
            rt_data = 32'd0;
        end else if (wb_we && rt_addr == wb_addr) begin
            rt_data = wb_data;
        end
    end

endmodule
